// File: rtl/video_sync_h_lock.sv
// Horizontal sync receiver: measures incoming hsync period/width on the cend
// strobe and locks a flywheel hcount to it, regenerating line_start.
module video_sync_h_lock #(
  parameter int HPERIOD    = 448,
  parameter int PERIOD_TOL = 2,
  parameter int LOCK_CNT   = 4,
  parameter int MISS_MAX   = 3,
  parameter int SYNC_OFS   = 10,
  parameter int LINE_POS   = 88
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cend,
  input  logic       hsync_in,
  output logic       locked,
  output logic [8:0] hcount,
  output logic       line_start,
  output logic [9:0] period_meas,
  output logic [6:0] width_meas,
  output logic       phase_err
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(MISS_MAX + 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 hs_q, hs_d;
  logic                 run_q, run_d;
  logic [9:0]           per_cnt_q, per_cnt_d;
  logic [6:0]           wid_cnt_q, wid_cnt_d;
  logic [9:0]           period_meas_q, period_meas_d;
  logic [6:0]           width_meas_q, width_meas_d;
  logic [8:0]           hcount_q, hcount_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic                 locked_q, locked_d;
  logic                 line_start_q, line_start_d;
  logic                 phase_err_q, phase_err_d;

  logic       rise;
  logic       fall;
  logic [9:0] per_inc;
  logic       good;
  logic       miss_thresh;

  // Edges are only meaningful on a cend tick; between ticks nothing advances.
  assign rise = cend & hsync_in & ~hs_q;
  assign fall = cend & ~hsync_in & hs_q;

  assign per_inc     = (per_cnt_q == 10'h3ff) ? 10'h3ff : per_cnt_q + 10'd1;
  assign good        = (per_inc >= 10'(HPERIOD - PERIOD_TOL)) &&
                       (per_inc <= 10'(HPERIOD + PERIOD_TOL));
  assign miss_thresh = ({1'b0, per_cnt_q} + 11'd1) == 11'(HPERIOD + PERIOD_TOL);

  always_comb begin
    state_d       = state_q;
    hs_d          = hs_q;
    run_d         = run_q;
    per_cnt_d     = per_cnt_q;
    wid_cnt_d     = wid_cnt_q;
    period_meas_d = period_meas_q;
    width_meas_d  = width_meas_q;
    hcount_d      = hcount_q;
    match_d       = match_q;
    miss_d        = miss_q;
    locked_d      = locked_q;
    line_start_d  = 1'b0;
    phase_err_d   = 1'b0;

    if (cend) begin
      hs_d      = hsync_in;
      per_cnt_d = per_inc;

      if (rise) begin
        period_meas_d = per_inc;
        per_cnt_d     = '0;
        wid_cnt_d     = 7'd1;
        run_d         = 1'b1;
      end else if (hsync_in && (wid_cnt_q != 7'h7f)) begin
        wid_cnt_d = wid_cnt_q + 7'd1;
      end

      if (fall) width_meas_d = wid_cnt_q;

      if (run_q) begin
        hcount_d = (hcount_q == 9'(HPERIOD - 1)) ? 9'd0 : hcount_q + 9'd1;
      end

      case (state_q)
        SEARCH: begin
          if (rise) begin
            state_d  = ACQUIRE;
            match_d  = '0;
            hcount_d = 9'(SYNC_OFS);
          end
        end
        ACQUIRE: begin
          if (rise) begin
            hcount_d = 9'(SYNC_OFS);
            if (good) begin
              match_d = match_q + 1'b1;
              if ((match_q + 1'b1) == MATCH_W'(LOCK_CNT)) begin
                state_d  = LOCKED;
                miss_d   = '0;
                locked_d = 1'b1;
              end
            end else begin
              match_d = '0;
            end
          end else if (per_inc == 10'h3ff) begin
            state_d = SEARCH;
            match_d = '0;
          end
        end
        LOCKED: begin
          if (rise && good) begin
            hcount_d = 9'(SYNC_OFS);
            miss_d   = '0;
          end else if (rise || miss_thresh) begin
            // Bad rise keeps the flywheel phase; a missing sync re-arms the
            // period counter so the next miss lands one nominal line later.
            phase_err_d = 1'b1;
            if (!rise) per_cnt_d = 10'(PERIOD_TOL);
            if ((miss_q + 1'b1) == MISS_W'(MISS_MAX)) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              match_d  = '0;
              miss_d   = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: begin
          state_d  = SEARCH;
          locked_d = 1'b0;
        end
      endcase

      line_start_d = locked_d && (hcount_d == 9'(LINE_POS));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b0;
      run_q         <= 1'b0;
      per_cnt_q     <= '0;
      wid_cnt_q     <= '0;
      period_meas_q <= '0;
      width_meas_q  <= '0;
      hcount_q      <= '0;
      match_q       <= '0;
      miss_q        <= '0;
      locked_q      <= 1'b0;
      line_start_q  <= 1'b0;
      phase_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      run_q         <= run_d;
      per_cnt_q     <= per_cnt_d;
      wid_cnt_q     <= wid_cnt_d;
      period_meas_q <= period_meas_d;
      width_meas_q  <= width_meas_d;
      hcount_q      <= hcount_d;
      match_q       <= match_d;
      miss_q        <= miss_d;
      locked_q      <= locked_d;
      line_start_q  <= line_start_d;
      phase_err_q   <= phase_err_d;
    end
  end

  assign locked      = locked_q;
  assign hcount      = hcount_q;
  assign line_start  = line_start_q;
  assign period_meas = period_meas_q;
  assign width_meas  = width_meas_q;
  assign phase_err   = phase_err_q;

endmodule

// File: tb/tb_video_sync_h_lock.sv
// Bench for video_sync_h_lock: directed hsync lines, expected line_start and
// phase_err tick numbers queued by the driver and matched by a monitor.
module tb_video_sync_h_lock;

  logic       clk = 1'b0;
  logic       rst;
  logic       cend;
  logic       hsync_in;
  logic       locked;
  logic [8:0] hcount;
  logic       line_start;
  logic [9:0] period_meas;
  logic [6:0] width_meas;
  logic       phase_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int tick_cnt     = 0;
  int r;

  logic [31:0] ls_exp_q[$];
  logic [31:0] pe_exp_q[$];

  always #5 clk = ~clk;

  video_sync_h_lock dut (
    .clk        (clk),
    .rst        (rst),
    .cend       (cend),
    .hsync_in   (hsync_in),
    .locked     (locked),
    .hcount     (hcount),
    .line_start (line_start),
    .period_meas(period_meas),
    .width_meas (width_meas),
    .phase_err  (phase_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (tick %0d)", name, act, exp, tick_cnt);
    end
  endtask

  // Pops an expected tick number for every pulse the DUT presents.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (line_start) begin
        if (ls_exp_q.size() == 0) chk("line_start_unexpected", tick_cnt, -1);
        else chk("line_start_tick", tick_cnt, int'(ls_exp_q.pop_front()));
      end
      if (phase_err) begin
        if (pe_exp_q.size() == 0) chk("phase_err_unexpected", tick_cnt, -1);
        else chk("phase_err_tick", tick_cnt, int'(pe_exp_q.pop_front()));
      end
    end
  endtask

  // One cend tick: strobe high for one clk out of four.
  task automatic tick(input logic hs);
    cend     = 1'b1;
    hsync_in = hs;
    @(posedge clk); #1;
    tick_cnt++;
    cend = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic line(input int period, input int width, input logic exp_locked,
                      input int exp_hc, input int exp_per, input int stall_at);
    for (int i = 0; i < period; i++) begin
      tick(i < width);
      if (i == 0) begin
        chk("locked_at_rise", int'(locked), int'(exp_locked));
        chk("hcount_at_rise", int'(hcount), exp_hc);
        if (exp_per >= 0) chk("period_meas", int'(period_meas), exp_per);
      end
      if (i == stall_at) begin
        repeat (100) @(posedge clk);
        #1;
        chk("stall_hcount", int'(hcount), (exp_hc + stall_at) % 448);
        chk("stall_locked", int'(locked), int'(exp_locked));
        chk("stall_period", int'(period_meas), exp_per);
        chk("stall_width", int'(width_meas), width);
        chk("stall_line_start", int'(line_start), 0);
        chk("stall_phase_err", int'(phase_err), 0);
      end
    end
    if (width > 0 && width < period) chk("width_meas", int'(width_meas), width);
  endtask

  task automatic reset_check();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_hcount", int'(hcount), 0);
    chk("rst_line_start", int'(line_start), 0);
    chk("rst_period", int'(period_meas), 0);
    chk("rst_width", int'(width_meas), 0);
    chk("rst_phase_err", int'(phase_err), 0);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    cend     = 1'b0;
    hsync_in = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    reset_check();

    // Nominal 448/33 lines: lock on the 5th rise, line_start 78 ticks after rise.
    line(448, 33, 1'b0, 10, 1, -1);
    for (int k = 0; k < 3; k++) line(448, 33, 1'b0, 10, 448, -1);
    for (int k = 0; k < 2; k++) begin
      ls_exp_q.push_back(32'(tick_cnt + 1 + 78));
      line(448, 33, 1'b1, 10, 448, -1);
    end

    // Glitch: a 300-tick period is flagged without reloading hcount (10+300).
    ls_exp_q.push_back(32'(tick_cnt + 1 + 78));
    line(300, 33, 1'b1, 10, 448, -1);
    r = tick_cnt + 1;
    pe_exp_q.push_back(32'(r));
    ls_exp_q.push_back(32'(r + 226));
    line(448, 33, 1'b1, 310, 300, -1);
    ls_exp_q.push_back(32'(tick_cnt + 1 + 78));
    line(448, 33, 1'b1, 10, 448, -1);

    // Signal loss: misses at +450/+898/+1346, lock drops on the third.
    r = tick_cnt + 1;
    ls_exp_q.push_back(32'(r + 78));
    ls_exp_q.push_back(32'(r + 526));
    ls_exp_q.push_back(32'(r + 974));
    pe_exp_q.push_back(32'(r + 450));
    pe_exp_q.push_back(32'(r + 898));
    pe_exp_q.push_back(32'(r + 1346));
    line(1346, 33, 1'b1, 10, 448, -1);
    chk("loss_locked_before_3rd", int'(locked), 1);
    tick(1'b0);
    chk("loss_locked_after_3rd", int'(locked), 0);
    for (int k = 0; k < 100; k++) tick(1'b0);

    // Period 450 is within tolerance; the locked rise at exactly +450 wins over a miss.
    line(450, 33, 1'b0, 10, -1, -1);
    for (int k = 0; k < 3; k++) line(450, 33, 1'b0, 10, 450, -1);
    for (int k = 0; k < 2; k++) begin
      ls_exp_q.push_back(32'(tick_cnt + 1 + 78));
      line(450, 33, 1'b1, 10, 450, -1);
    end

    // Reset while locked, then relock with a 100-clk cend stall in a locked line.
    reset_check();
    line(448, 33, 1'b0, 10, 1, -1);
    for (int k = 0; k < 3; k++) line(448, 33, 1'b0, 10, 448, -1);
    ls_exp_q.push_back(32'(tick_cnt + 1 + 78));
    line(448, 33, 1'b1, 10, 448, -1);
    ls_exp_q.push_back(32'(tick_cnt + 1 + 78));
    line(448, 33, 1'b1, 10, 448, 77);

    // Period 451 is out of tolerance: never locks.
    reset_check();
    line(451, 33, 1'b0, 10, 1, -1);
    for (int k = 0; k < 5; k++) line(451, 33, 1'b0, 10, 451, -1);

    repeat (8) @(posedge clk);
    #1;
    chk("ls_expected_left", ls_exp_q.size(), 0);
    chk("pe_expected_left", pe_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
